// File: rtl/mcr3_pkg.sv
// Shared types and constants for the MCR3 ROM loader: game ids, ROM regions
// and the per-game sprite ROM base address.
package mcr3_pkg;

  typedef enum logic [1:0] {
    GAME_TAPPER   = 2'd0,
    GAME_TIMBER   = 2'd1,
    GAME_DOTRON   = 2'd2,
    GAME_DEMODERB = 2'd3
  } game_e;

  typedef enum logic [1:0] {
    REG_CPU = 2'd0,
    REG_SP  = 2'd1,
    REG_DL  = 2'd2
  } region_e;

  localparam logic [24:0] DL_BASE_DEF = 25'h32000;
  localparam int          FIFO_W      = 33;

  function automatic logic [24:0] sp_base(input game_e g);
    case (g)
      GAME_TIMBER:   return 25'h11000;
      GAME_DEMODERB: return 25'h14000;
      default:       return 25'h12000;
    endcase
  endfunction

endpackage

// File: rtl/mcr3_dl_fifo.sv
// Small synchronous FIFO holding captured {addr, data} download bytes.
// Pushes into a full FIFO are discarded; the producer is throttled upstream.
module mcr3_dl_fifo
  import mcr3_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = FIFO_W
) (
  input  logic                       clk_sys,
  input  logic                       RESET,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign do_push = push_i && (count_q != FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_push && !RESET) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mcr3_rom_loader.sv
// MCR3 ROM loader: captures the hps_io download stream, routes each byte to the
// CPU or sprite SDRAM port (toggle handshake) or the graphics BRAM strobe.
//
// state    | meaning
// ST_IDLE  | pop next FIFO byte; graphics bytes complete here in one cycle
// ST_ISSUE | port regs loaded; toggle req once the port has no request pending
// ST_WAIT  | request outstanding; return to idle when ack matches req
module mcr3_rom_loader
  import mcr3_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RST_CNT    = 16'hFFFF,
  parameter logic [24:0] DL_BASE    = DL_BASE_DEF
) (
  input  logic        clk_sys,
  input  logic        RESET,
  input  logic        status_reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_index,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [1:0]  mod_sel,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [22:0] port1_a,
  output logic [1:0]  port1_ds,
  output logic [15:0] port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [22:0] port2_a,
  output logic [1:0]  port2_ds,
  output logic [15:0] port2_d,
  output logic        dl_wr,
  output logic [24:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        rom_loaded,
  output logic        core_reset
);

  localparam int            CW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] WAIT_CNT = CW'(FIFO_DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  state_e state_q, state_d;

  // Power-up values only; these hold across RESET.
  logic        port1_req_q  = 1'b0;
  logic        port2_req_q  = 1'b0;
  logic [1:0]  mod_sel_q    = 2'd0;
  logic        rom_loaded_q = 1'b0;
  logic        rom_wr_prev_q = 1'b0;
  logic        dl_prev_q    = 1'b0;

  logic        sel_sp_q, sel_sp_d;
  logic [22:0] port1_a_q, port2_a_q;
  logic [1:0]  port1_ds_q, port2_ds_q;
  logic [15:0] port1_d_q, port2_d_q;
  logic        wait_q, dl_wr_q, core_reset_q;
  logic [24:0] dl_addr_q;
  logic [7:0]  dl_data_q;
  logic [15:0] cnt_q;

  logic          rom_strobe, push, pop;
  logic [32:0]   head;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [24:0]   head_addr, sp_base_w, dl_off;
  logic [7:0]    head_data;
  logic [18:0]   sp_off;
  logic [22:0]   sp_a;
  logic [1:0]    sp_ds;
  region_e       region;
  logic          load_p1, load_p2, dl_fire, tgl1, tgl2;
  logic          sel_req, sel_ack;

  assign rom_strobe = ioctl_wr && (ioctl_index == 8'd0);
  assign push       = rom_strobe && !rom_wr_prev_q;

  mcr3_dl_fifo #(.DEPTH(FIFO_DEPTH), .W(FIFO_W)) u_fifo (
    .clk_sys (clk_sys),
    .RESET   (RESET),
    .push_i  (push),
    .wdata_i ({ioctl_addr, ioctl_dout}),
    .pop_i   (pop),
    .rdata_o (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head_addr = head[32:8];
  assign head_data = head[7:0];
  assign sp_base_w = sp_base(game_e'(mod_sel_q));
  assign sp_off    = 19'(head_addr - sp_base_w);
  assign dl_off    = head_addr - DL_BASE;

  always_comb begin
    if (head_addr >= DL_BASE)        region = REG_DL;
    else if (head_addr >= sp_base_w) region = REG_SP;
    else                             region = REG_CPU;
  end

  // Dotron packs its sprite ROMs differently from the other three games.
  always_comb begin
    if (game_e'(mod_sel_q) == GAME_DOTRON) begin
      sp_a  = {8'd0, sp_off[13:0], sp_off[15]};
      sp_ds = {sp_off[14], ~sp_off[14]};
    end else begin
      sp_a  = {5'd0, sp_off[18:17], sp_off[14:0], sp_off[16]};
      sp_ds = {sp_off[15], ~sp_off[15]};
    end
  end

  assign sel_req = sel_sp_q ? port2_req_q : port1_req_q;
  assign sel_ack = sel_sp_q ? port2_ack   : port1_ack;

  always_comb begin
    state_d  = state_q;
    sel_sp_d = sel_sp_q;
    pop      = 1'b0;
    load_p1  = 1'b0;
    load_p2  = 1'b0;
    dl_fire  = 1'b0;
    tgl1     = 1'b0;
    tgl2     = 1'b0;
    if (!RESET) begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop = 1'b1;
            case (region)
              REG_DL: dl_fire = 1'b1;
              REG_SP: begin
                load_p2  = 1'b1;
                sel_sp_d = 1'b1;
                state_d  = ST_ISSUE;
              end
              default: begin
                load_p1  = 1'b1;
                sel_sp_d = 1'b0;
                state_d  = ST_ISSUE;
              end
            endcase
          end
        end
        // Guard also absorbs an ack that arrives late after a RESET in WAIT.
        ST_ISSUE: begin
          if (sel_req == sel_ack) begin
            tgl1    = !sel_sp_q;
            tgl2    = sel_sp_q;
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (sel_ack == sel_req) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      wait_q  <= 1'b0;
      dl_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= (fifo_count >= WAIT_CNT);
      dl_wr_q <= dl_fire;
    end
  end

  always_ff @(posedge clk_sys) begin
    sel_sp_q      <= sel_sp_d;
    rom_wr_prev_q <= rom_strobe;
    dl_prev_q     <= ioctl_download;
    if (load_p1) begin
      port1_a_q  <= head_addr[23:1];
      port1_ds_q <= {head_addr[0], ~head_addr[0]};
      port1_d_q  <= {head_data, head_data};
    end
    if (load_p2) begin
      port2_a_q  <= sp_a;
      port2_ds_q <= sp_ds;
      port2_d_q  <= {head_data, head_data};
    end
    if (dl_fire) begin
      dl_addr_q <= dl_off;
      dl_data_q <= head_data;
    end
    if (tgl1) port1_req_q <= ~port1_req_q;
    if (tgl2) port2_req_q <= ~port2_req_q;
    if (ioctl_wr && (ioctl_index == 8'd1)) mod_sel_q <= ioctl_dout[1:0];
    if (ioctl_download && !dl_prev_q && (ioctl_index == 8'd0))
      rom_loaded_q <= 1'b0;
    else if (!ioctl_download && fifo_empty && (state_q == ST_IDLE))
      rom_loaded_q <= 1'b1;
  end

  // Core reset is released after the load, then re-pulsed once at cnt==1.
  always_ff @(posedge clk_sys) begin
    if (RESET || status_reset || !rom_loaded_q) cnt_q <= RST_CNT;
    else if (cnt_q != 16'd0)                    cnt_q <= cnt_q - 16'd1;
    core_reset_q <= RESET || status_reset || !rom_loaded_q || (cnt_q == 16'd1);
  end

  assign ioctl_wait = wait_q;
  assign mod_sel    = mod_sel_q;
  assign port1_req  = port1_req_q;
  assign port1_a    = port1_a_q;
  assign port1_ds   = port1_ds_q;
  assign port1_d    = port1_d_q;
  assign port2_req  = port2_req_q;
  assign port2_a    = port2_a_q;
  assign port2_ds   = port2_ds_q;
  assign port2_d    = port2_d_q;
  assign dl_wr      = dl_wr_q;
  assign dl_addr    = dl_addr_q;
  assign dl_data    = dl_data_q;
  assign rom_loaded = rom_loaded_q;
  assign core_reset = core_reset_q;

endmodule
